blake_msg_sched: RTL and testbench

Sequenced message/constant scheduler for the BLAKE-512 compression core. It latches one padded single-block message and streams, per G-step, the permuted message words m[σ(2i)], m[σ(2i+1)] and constants c[σ(2i)], c[σ(2i+1)] for NUM_G parallel G-function lanes. The stream covers all ROUNDS rounds, using a valid/ready handshake and registered outputs. It sits between the header/nonce loader and the G-lane datapath, and generalises the two-lane combinational mux in lane count, round count and message length.

---
 rtl/blake512_pkg.sv | 17 +
 rtl/blake_sigma_rom.sv | 9 +
 rtl/blake_msg_sched.sv | 104 ++++++++++
 tb/tb_blake_msg_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/blake512_pkg.sv
// blake512_pkg: BLAKE-512 round constants, sigma permutation rows, padding bytes and scheduler state type
package blake512_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [7:0] PAD_BEGIN = 8'h80;
  localparam logic [7:0] PAD_END = 8'h01;
  localparam logic [63:0] CB [0:15] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };
  localparam logic [63:0] SIGMA [0:9] = '{
    64'h0123456789ABCDEF, 64'hEA489FD61C02B753, 64'hB8C052FDAE367194, 64'h7931DCBE265A40F8,
    64'h905724AFE1BC683D, 64'h2C6A0B834D75FE19, 64'hC51FED4A0763928B, 64'hDB7EC13950F4862A,
    64'h6FE9B308C2D714A5, 64'hA2847615FB9E3CD0
  };
endpackage

// File: rtl/blake_sigma_rom.sv
// blake_sigma_rom: round (4b) in, sigma row out as 16 nibbles with element 0 in the MSBs; rounds wrap mod 10
module blake_sigma_rom
  import blake512_pkg::*;
(
  input  logic [3:0]  round,
  output logic [63:0] row
);
  assign row = SIGMA[round >= 4'd10 ? round - 4'd10 : round];
endmodule

// File: rtl/blake_msg_sched.sv
// blake_msg_sched: latches a padded message on start&&ready and streams per-lane m0/m1/k0/k1 beats with round/step/last over valid/ready
module blake_msg_sched
  import blake512_pkg::*;
#(
  parameter int NUM_G = 2,
  parameter int ROUNDS = 16,
  parameter int LEN_BITS = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   msg_in,
  output logic                  ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_G*64-1:0]   m0,
  output logic [NUM_G*64-1:0]   m1,
  output logic [NUM_G*64-1:0]   k0,
  output logic [NUM_G*64-1:0]   k1,
  output logic [3:0]            out_round,
  output logic [1:0]            out_step,
  output logic                  out_last
);
  localparam int N = LEN_BITS / 64;
  localparam logic [2:0] LAST_STEP = 3'(8 / NUM_G - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
  state_t state;
  logic [63:0] w [16];
  logic [63:0] pw [16];
  logic [1023:0] padded;
  logic [3:0] cur_round;
  logic [2:0] cur_step;
  logic [63:0] row;
  logic [NUM_G*64-1:0] nm0, nm1, nk0, nk1;
  logic accept, load, step_wrap;
  assign accept = start && ready;
  assign load = state == RUN && (!out_valid || (out_ready && !out_last));
  assign step_wrap = cur_step == LAST_STEP;
  assign padded = {msg_in, {(1024 - LEN_BITS){1'b0}}};
  always_comb begin
    for (int i = 0; i < 16; i++) pw[i] = padded[1023 - 64*i -: 64];
    pw[N] = {PAD_BEGIN, 56'h0};
    pw[13] = pw[13] | {56'h0, PAD_END};
    pw[15] = 64'(LEN_BITS);
  end
  always_ff @(posedge clk)
    if (accept)
      for (int i = 0; i < 16; i++) w[i] <= pw[i];
  blake_sigma_rom u_sigma (.round(cur_round), .row(row));
  for (genvar j = 0; j < NUM_G; j++) begin : g_lane
    logic [2:0] g;
    logic [63:0] srow;
    logic [3:0] s0, s1;
    assign g = 3'(cur_step * NUM_G + j);
    assign srow = row << {g, 3'b000};
    assign s0 = srow[63:60];
    assign s1 = srow[59:56];
    assign nm0[64*j +: 64] = w[s0];
    assign nm1[64*j +: 64] = w[s1];
    assign nk0[64*j +: 64] = CB[s0];
    assign nk1[64*j +: 64] = CB[s1];
  end
  // cur_round/cur_step point at the next beat to load; the output register is a one-deep stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_round <= '0;
      out_step <= '0;
      m0 <= '0;
      m1 <= '0;
      k0 <= '0;
      k1 <= '0;
      cur_round <= '0;
      cur_step <= '0;
    end else begin
      if (accept) begin
        state <= RUN;
        ready <= 1'b0;
        cur_round <= '0;
        cur_step <= '0;
      end
      if (load) begin
        out_valid <= 1'b1;
        m0 <= nm0;
        m1 <= nm1;
        k0 <= nk0;
        k1 <= nk1;
        out_round <= cur_round;
        out_step <= cur_step[1:0];
        out_last <= cur_round == LAST_ROUND && step_wrap;
        cur_step <= step_wrap ? 3'd0 : cur_step + 3'd1;
        cur_round <= step_wrap ? cur_round + 4'd1 : cur_round;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
        state <= IDLE;
        ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_blake_msg_sched.sv
// tb_blake_msg_sched: randomized self-checking bench for four scheduler configurations against a word/sigma reference model
module tb_blake_msg_sched;
  localparam int GS [4] = '{2, 4, 1, 4};
  localparam int LS [4] = '{640, 640, 832, 64};
  localparam int RS [4] = '{16, 16, 16, 10};
  localparam logic [63:0] CBT [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };
  localparam int SIG [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };
  logic clk = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  for (genvar k = 0; k < 4; k++) begin : g_inst
    localparam int G = GS[k];
    localparam int L = LS[k];
    localparam int R = RS[k];
    localparam int ST = 8 / G;
    localparam int TOTAL = R * ST;
    localparam int N = L / 64;
    localparam int RST_AT = TOTAL > 20 ? 20 : TOTAL / 2;
    logic rst, start, out_ready, ready, out_valid, out_last, done;
    logic [L-1:0] msg;
    logic [G*64-1:0] m0, m1, k0, k1;
    logic [3:0] out_round;
    logic [1:0] out_step;
    logic [63:0] w [16];
    int beats;
    blake_msg_sched #(.NUM_G(G), .ROUNDS(R), .LEN_BITS(L)) dut (
      .clk(clk), .rst(rst), .start(start), .msg_in(msg), .ready(ready),
      .out_valid(out_valid), .out_ready(out_ready), .m0(m0), .m1(m1), .k0(k0), .k1(k1),
      .out_round(out_round), .out_step(out_step), .out_last(out_last)
    );
    task automatic set_msg(input bit rnd);
      logic [63:0] word;
      for (int i = 0; i < 16; i++) w[i] = '0;
      for (int i = 0; i < N; i++) begin
        word = rnd ? {$urandom, $urandom} : 64'(i);
        msg[L-1-64*i -: 64] = word;
        w[i] = word;
      end
      w[N] = 64'h8000_0000_0000_0000;
      w[13] = w[13] | 64'h1;
      w[15] = 64'(L);
    endtask
    task automatic expect_beat(input int b, output logic [255:0] em0, em1, ek0, ek1);
      int r, s, gi, a, c;
      r = (b / ST) % 10;
      s = b % ST;
      em0 = '0; em1 = '0; ek0 = '0; ek1 = '0;
      for (int j = 0; j < G; j++) begin
        gi = s * G + j;
        a = SIG[r][2*gi];
        c = SIG[r][2*gi+1];
        em0[64*j +: 64] = w[a];
        em1[64*j +: 64] = w[c];
        ek0[64*j +: 64] = CBT[a];
        ek1[64*j +: 64] = CBT[c];
      end
    endtask
    task automatic run_block(input bit stall, input bit poke, input int rst_at, output int nb);
      logic [255:0] em0, em1, ek0, ek1, pm0;
      bit pstall;
      nb = 0;
      pstall = 0;
      pm0 = '0;
      @(negedge clk);
      check("idle_ready", 256'(ready), 256'(1));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc < 4000; cyc++) begin
        @(negedge clk);
        check("run_ready", 256'(ready), 256'(0));
        if (pstall) begin
          check("hold_valid", 256'(out_valid), 256'(1));
          check("hold_m0", 256'(m0), pm0);
        end else if (!stall && cyc > 1) check("no_gap", 256'(out_valid), 256'(1));
        if (out_valid) begin
          expect_beat(nb, em0, em1, ek0, ek1);
          check("m0", 256'(m0), em0);
          check("m1", 256'(m1), em1);
          check("k0", 256'(k0), ek0);
          check("k1", 256'(k1), ek1);
          check("round", 256'(out_round), 256'(nb / ST));
          check("step", 256'(out_step), 256'((nb % ST) % 4));
          check("last", 256'(out_last), 256'(nb == TOTAL - 1));
          if (nb == 0) begin
            check("k0_beat0", 256'(k0[63:0]), 256'(64'h243F6A8885A308D3));
            check("k1_beat0", 256'(k1[63:0]), 256'(64'h13198A2E03707344));
          end
          if (nb == ST) begin
            check("m0_r1s0", 256'(m0[63:0]), 256'(0));
            check("k0_r1s0", 256'(k0[63:0]), 256'(64'h0801F2E2858EFC16));
          end
        end
        if (out_valid && nb == rst_at) begin
          rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
          @(negedge clk);
          check("rst_valid", 256'(out_valid), 256'(0));
          check("rst_ready", 256'(ready), 256'(1));
          return;
        end
        out_ready = stall ? ($urandom_range(2) != 0) : 1'b1;
        start = poke ? ($urandom_range(3) == 0) : 1'b0;
        pstall = out_valid && !out_ready;
        pm0 = 256'(m0);
        if (out_valid && out_ready) begin
          nb++;
          if (out_last) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check("end_valid", 256'(out_valid), 256'(0));
            check("end_ready", 256'(ready), 256'(1));
            return;
          end
        end
      end
      check("timeout_beats", 256'(nb), 256'(TOTAL));
    endtask
    initial begin
      done = 1'b0;
      rst = 1'b1;
      start = 1'b1;
      out_ready = 1'b0;
      msg = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_ready", 256'(ready), 256'(1));
      check("reset_valid", 256'(out_valid), 256'(0));
      check("reset_last", 256'(out_last), 256'(0));
      check("reset_round", 256'(out_round), 256'(0));
      check("reset_step", 256'(out_step), 256'(0));
      check("reset_data", 256'({m0, m1, k0, k1}), 256'(0));
      set_msg(1'b0);
      run_block(1'b0, 1'b0, -1, beats);
      check("beats_plain", 256'(beats), 256'(TOTAL));
      set_msg(1'b1);
      run_block(1'b1, 1'b1, -1, beats);
      check("beats_stall", 256'(beats), 256'(TOTAL));
      set_msg(1'b1);
      run_block(1'b0, 1'b0, RST_AT, beats);
      check("beats_rst", 256'(beats), 256'(RST_AT));
      run_block(1'b0, 1'b0, -1, beats);
      check("beats_after_rst", 256'(beats), 256'(TOTAL));
      done = 1'b1;
    end
  end
  initial begin
    int cyc;
    for (cyc = 0; cyc < 40000; cyc++) begin
      @(posedge clk);
      if (g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done) break;
    end
    if (cyc >= 40000) check("all_done", 256'(0), 256'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
